// File: rtl/pipeline_ctrl.sv
// Hazard/stall/flush controller for a 5-stage in-order pipeline: memory freeze,
// halt drain, load-use and branch stalls, redirects, memory timeout and perf counters.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_req,
    input  logic             branch_stall_req,
    input  logic             redirect_req,
    input  logic             dmem_busy,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             clr_cnt,
    output logic             PCWrite,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             stall_MEM_WB,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic             halted,
    output logic             mem_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        DRAIN    = 2'b10,
        HALTED   = 2'b11
    } state_e;

    localparam logic [8:0] TIMEOUT    = 9'(MEM_TIMEOUT);
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic [7:0]       busy_q, busy_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             redirect_taken;
    logic             stall_inc;

    // State register. Reset is synchronous, so rst_n is sampled like any data input.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the pre-edge values.
        if (!rst_n) begin
            state_q     <= RUN;
            drain_q     <= '0;
            busy_q      <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state logic; MEM_WAIT with memory ready is decoded exactly like RUN.
    always_comb begin
        // NOTE: defaults first so every path assigns every variable and no latch is inferred.
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (dmem_busy) begin
                    state_d = MEM_WAIT;
                end else if (halt_req) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (!dmem_busy) begin
                    drain_d = drain_q - 4'd1;
                    if (drain_q <= 4'd1) state_d = HALTED;
                end
            end
            HALTED: begin
                if (resume) state_d = RUN;
            end
        endcase
    end

    // Output decode: reset pattern, then halted, then memory freeze, then drain, then RUN priorities.
    always_comb begin
        PCWrite        = 1'b1;
        stall_IF_ID    = 1'b0;
        stall_ID_EX    = 1'b0;
        stall_EX_MEM   = 1'b0;
        stall_MEM_WB   = 1'b0;
        flush_IF_ID    = 1'b0;
        flush_ID_EX    = 1'b0;
        flush_EX_MEM   = 1'b0;
        flush_MEM_WB   = 1'b0;
        halted         = 1'b0;
        redirect_taken = 1'b0;
        if (!rst_n) begin
            PCWrite      = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (state_q == HALTED) begin
            PCWrite      = 1'b0;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            stall_MEM_WB = 1'b1;
            halted       = 1'b1;
        end else if (dmem_busy) begin
            // MEM holds its access; a bubble goes to WB so nothing retires twice.
            PCWrite      = 1'b0;
            stall_IF_ID  = 1'b1;
            stall_ID_EX  = 1'b1;
            stall_EX_MEM = 1'b1;
            flush_MEM_WB = 1'b1;
        end else if (state_q == DRAIN || halt_req) begin
            PCWrite     = 1'b0;
            flush_IF_ID = 1'b1;
        end else if (load_use_req || branch_stall_req) begin
            PCWrite     = 1'b0;
            stall_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
        end else if (redirect_req) begin
            flush_IF_ID    = 1'b1;
            redirect_taken = 1'b1;
        end
    end

    assign stall_inc = !PCWrite && (state_q == RUN || state_q == MEM_WAIT);

    // Performance counters and memory-timeout watchdog.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && stall_cnt_q != '1)      stall_cnt_d = stall_cnt_q + 1'b1;
            if (redirect_taken && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
        end
        busy_d = '0;
        if (dmem_busy) busy_d = (busy_q == 8'hFF) ? busy_q : busy_q + 8'd1;
        mem_err_d = mem_err_q | (dmem_busy && (({1'b0, busy_q} + 9'd1) >= TIMEOUT));
    end

    assign state     = state_q;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning non-frozen cycles spent draining EX/MEM/WB after halt accepted (legal 1..15).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning consecutive dmem_busy cycles that set mem_err (legal 1..255).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of performance counters.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports load_use_req, branch_stall_req, redirect_req, dmem_busy, halt_req, resume, clr_cnt  input  1 each: load-use hazard in ID, branch operand not ready in ID, taken branch/jump resolved in ID, data memory not ready in MEM, ecall/ebreak in ID, leave halt, clear counters.
REQ-007 SHALL have ports PCWrite, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB, flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  output  1 each: PC enable, pipeline register holds, pipeline register bubble injects.
REQ-008 SHALL have ports halted  output  1; mem_err  output  1 (sticky); state  output  2 (RUN=00, MEM_WAIT=01, DRAIN=10, HALTED=11); stall_cnt, flush_cnt  output  CNT_W.

Function
REQ-009 SHALL drive control outputs combinationally from registered state and current inputs; defaults PCWrite=1, all stall/flush=0.
REQ-010 SHALL apply priority dmem_busy > halt_req > (load_use_req | branch_stall_req) > redirect_req in RUN; lower-priority requests are ignored in that cycle (requesters re-present).
REQ-011 SHALL freeze on dmem_busy in RUN, MEM_WAIT or DRAIN: PCWrite=0, stall_IF_ID=stall_ID_EX=stall_EX_MEM=1, flush_MEM_WB=1.
REQ-012 SHALL, on halt_req in RUN without dmem_busy: PCWrite=0, flush_IF_ID=1; next state DRAIN, drain counter loaded with DRAIN_CYCLES.
REQ-013 SHALL, on load_use_req or branch_stall_req (no higher request): PCWrite=0, stall_IF_ID=1, flush_ID_EX=1; state stays RUN.
REQ-014 SHALL, on redirect_req alone: PCWrite=1, flush_IF_ID=1; flush_cnt increments.
REQ-015 SHALL transition RUN->MEM_WAIT on dmem_busy; MEM_WAIT->RUN on first cycle with dmem_busy=0 (that cycle decoded as RUN per REQ-010..014).
REQ-016 SHALL in DRAIN drive PCWrite=0, flush_IF_ID=1 each non-frozen cycle, decrement drain counter; when counter==1 and dmem_busy=0, next state HALTED; frozen cycles do not decrement.
REQ-017 SHALL ignore load_use_req, branch_stall_req, redirect_req, halt_req in DRAIN and HALTED.
REQ-018 SHALL in HALTED drive PCWrite=0, all four stall=1, all flush=0, halted=1; resume=1 -> RUN next cycle; resume outside HALTED ignored.
REQ-019 SHALL count consecutive dmem_busy cycles (8-bit, saturating), clear on any cycle dmem_busy=0; on reaching MEM_TIMEOUT set mem_err, held until reset; no state change.
REQ-020 SHALL increment stall_cnt on every cycle PCWrite=0 in RUN or MEM_WAIT; both counters saturate at all-ones; clr_cnt zeroes both and overrides same-cycle increment.

Reset
REQ-021 SHALL, on rising edge with rst_n=0: state=RUN, drain counter=0, busy counter=0, mem_err=0, stall_cnt=flush_cnt=0.
REQ-022 SHALL, while rst_n=0, force PCWrite=0, all flush=1, all stall=0, halted=0, regardless of inputs; reset mid-DRAIN or mid-HALTED returns to RUN.

Verification
REQ-023 SHALL cover load-use: load_use_req=1 one cycle in RUN -> PCWrite=0, stall_IF_ID=1, flush_ID_EX=1, stall_cnt 0->1, state=00.
REQ-024 SHALL cover priority: load_use_req=redirect_req=dmem_busy=1 -> freeze pattern REQ-011 only, flush_IF_ID=0, flush_cnt unchanged, state->01.
REQ-025 SHALL cover halt drain: halt_req at T, DRAIN_CYCLES=3, dmem_busy=1 at T+2 only -> state=10 T+1..T+4, 11 at T+5, halted=1, stalls all 1.
REQ-026 SHALL cover resume: in HALTED, resume=1 with redirect_req=1 -> next cycle state=00, redirect honoured only in RUN cycle.
REQ-027 SHALL cover timeout: MEM_TIMEOUT=4, dmem_busy held 4 cycles -> mem_err=1 after 4th edge, stays 1 after dmem_busy drops, cleared only by rst_n=0.
REQ-028 SHALL cover counters: stall_cnt preset via 65535 stalls -> stays 16'hFFFF; clr_cnt with stall same cycle -> 0.
